// File: rtl/led_anim_scheduler_if.sv
// Request/status bundle between the keypad code decoder and the LED animation scheduler.
// master: requester side; slave: scheduler side.
interface led_anim_scheduler_if;
    logic       req_on;
    logic       req_off;
    logic       req_egg;
    logic [1:0] sel;
    logic [4:0] frame;
    logic       frame_tick;
    logic       busy;
    logic       pending;
    logic       done;

    modport master (
        output req_on, req_off, req_egg,
        input  sel, frame, frame_tick, busy, pending, done
    );

    modport slave (
        input  req_on, req_off, req_egg,
        output sel, frame, frame_tick, busy, pending, done
    );
endinterface

// File: rtl/led_anim_scheduler.sv
// Arbitrates LED animation requests, paces frames with a tick divider and
// keeps one pending request so a request arriving mid-animation is not lost.
module led_anim_scheduler #(
    parameter int unsigned TICK_DIV = 8388608,
    parameter int unsigned LAST_ON  = 15,
    parameter int unsigned LAST_OFF = 8,
    parameter int unsigned LAST_EGG = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    led_anim_scheduler_if.slave         bus
);
    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [4:0]    frame_q, frame_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [1:0]    pend_sel_q, pend_sel_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          req_any;
    logic [1:0]    req_code;
    logic [4:0]    last_frame;

    function automatic logic [4:0] last_of(input logic [1:0] s);
        case (s)
            2'd1:    return 5'(LAST_ON);
            2'd2:    return 5'(LAST_OFF);
            2'd3:    return 5'(LAST_EGG);
            default: return 5'd0;
        endcase
    endfunction

    always_comb begin
        req_any    = bus.req_on | bus.req_off | bus.req_egg;
        // off > on > egg when pulses coincide
        req_code   = bus.req_off ? 2'd2 : bus.req_on ? 2'd1 : bus.req_egg ? 2'd3 : 2'd0;
        last_frame = last_of(sel_q);

        state_d    = state_q;
        sel_d      = sel_q;
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        busy_d     = busy_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (req_any) begin
                    state_d = PLAY;
                    sel_d   = req_code;
                    frame_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            PLAY: begin
                if (req_any) begin
                    pend_d     = 1'b1;
                    pend_sel_d = req_code;
                end
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (frame_q == last_frame) begin
                        // A request on the expiry cycle is queued and consumed at once.
                        if (req_any || pend_q) begin
                            sel_d   = req_any ? req_code : pend_sel_q;
                            frame_d = '0;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = HOLD;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        frame_d = frame_q + 5'd1;
                        tick_d  = 1'b1;
                        done_d  = ((frame_q + 5'd1) == last_frame);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            frame_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_sel_q <= '0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.frame      = frame_q;
    assign bus.frame_tick = tick_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = pend_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_led_anim_scheduler.sv
// Bench for led_anim_scheduler: directed scenarios plus random request traffic,
// every cycle compared against a timing-arithmetic reference model.
module tb_led_anim_scheduler;
    localparam int TD = 4;

    logic clk;
    logic reset;
    led_anim_scheduler_if bus ();

    led_anim_scheduler #(
        .TICK_DIV (TD),
        .LAST_ON  (15),
        .LAST_OFF (8),
        .LAST_EGG (30)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0 idle, 1 playing, 2 holding; animation start recorded as an edge number.
    int m_mode  = 0;
    int m_anim  = 0;
    int m_start = 0;
    int m_pend  = 0;
    int m_pcode = 0;
    int edge_n  = 0;

    function automatic int last_of(input int a);
        case (a)
            1:       return 15;
            2:       return 8;
            3:       return 30;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, obs, exp);
    endtask

    task automatic step(input logic on, input logic off, input logic egg, input logic rst);
        int r;
        int e;
        int x_sel, x_frame, x_tick, x_busy, x_done;
        @(negedge clk);
        bus.req_on  = on;
        bus.req_off = off;
        bus.req_egg = egg;
        reset       = rst;
        @(posedge clk);
        edge_n++;
        r = off ? 2 : on ? 1 : egg ? 3 : 0;
        if (rst) begin
            m_mode = 0; m_anim = 0; m_pend = 0; m_pcode = 0;
        end else if (m_mode != 1) begin
            if (r != 0) begin m_mode = 1; m_anim = r; m_start = edge_n; end
        end else begin
            if (r != 0) begin m_pend = 1; m_pcode = r; end
            if (edge_n - m_start == (last_of(m_anim) + 1) * TD) begin
                if (m_pend != 0) begin
                    m_anim = m_pcode; m_start = edge_n; m_pend = 0;
                end else begin
                    m_mode = 2;
                end
            end
        end
        x_sel = m_anim; x_frame = 0; x_tick = 0; x_busy = 0; x_done = 0;
        if (m_mode == 1) begin
            e       = edge_n - m_start;
            x_frame = e / TD;
            x_tick  = (e > 0 && e % TD == 0) ? 1 : 0;
            x_done  = (x_tick == 1 && x_frame == last_of(m_anim)) ? 1 : 0;
            x_busy  = 1;
        end else if (m_mode == 2) begin
            x_frame = last_of(m_anim);
        end
        #1;
        check("sel",        int'(bus.sel),        x_sel);
        check("frame",      int'(bus.frame),      x_frame);
        check("frame_tick", int'(bus.frame_tick), x_tick);
        check("busy",       int'(bus.busy),       x_busy);
        check("pending",    int'(bus.pending),    m_pend);
        check("done",       int'(bus.done),       x_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.req_on = 1'b0; bus.req_off = 1'b0; bus.req_egg = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        // turn-on from idle through to hold
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(70);
        // off then egg queued mid-play; egg follows with no gap
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(170);
        // simultaneous on+off from idle: off wins
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(40);
        // restart off from hold, then egg and on queued: on wins
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(100);
        // reset mid-play at frame 5 with a pending request
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);
        // request coinciding with reset is dropped
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(5);
        // off to hold, then replay off from hold
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(40);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(40);
        // request on the exact expiry cycle of the final frame
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(35);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(130);
        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 40) == 0, ($urandom % 40) == 0,
                 ($urandom % 40) == 0, ($urandom % 600) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
